// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with valid/ready byte intake
module uart_tx_frame #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int SH_W         = DATA_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (BAUD_DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_frame: BAUD_DIVISOR must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_c;
  logic              par_bit;
  logic              tick;

  always_comb begin
    if (PARITY == 1)      par_bit = ~^data;
    else if (PARITY == 2) par_bit = ^data;
    else                  par_bit = 1'b1;
  end

  assign tick = (baud_cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_c    = 1'b0;
    if (state_q != S_IDLE) baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    // tx_d is the level for the next clock, so each branch sets up the bit being entered
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        tx_d    = 1'b1;
        if (valid) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          shreg_d    = {par_bit, data};
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = {1'b1, shreg_q[SH_W-1:1]};
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q != DATA_LAST) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b1, shreg_q[SH_W-1:1]};
          end else if (PARITY != 0) begin
            state_d = S_PAR;
            tx_d    = shreg_q[0];
            shreg_d = {1'b1, shreg_q[SH_W-1:1]};
          end else begin
            state_d   = S_STOP;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          state_d   = S_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (tick && bit_cnt_q == STOP_LAST) begin
          ready_c = 1'b1;
          if (valid) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            shreg_d   = {par_bit, data};
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (tick) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign ready = ready_c & ~rst;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule
